mmio_master: RTL and testbench

MMIO_MASTER -- requirements
Module: mmio_master

---
 rtl/mmio_master.sv | 170 +++++++++++++++++
 tb/tb_mmio_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_master.sv
// CPU-side MMIO bus master: one access at a time, lane steering, error responses.
// Optional MMIO_MASTER_TIMEOUT_EN bounds how long a claimed access may wait for mmio_done.
module mmio_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        req_ready,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mmio_read,
    output logic        mmio_write,
    output logic [31:0] mmio_addr,
    output logic [31:0] mmio_write_data,
    input  logic        mmio_work,
    input  logic        mmio_done,
    input  logic [31:0] mmio_read_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_addr_lo;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_first;
    logic        w_illegal;
    logic        w_timeout;
    logic [31:0] w_store_data;
    logic [31:0] w_load_data;

    function automatic logic f_illegal(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] f_store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] res;
        case (size)
            2'b00:   res = {4{wdata[7:0]}};
            2'b01:   res = {2{wdata[15:0]}};
            default: res = wdata;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_load_lane(input logic [1:0] size, input logic [1:0] lo,
                                                input logic sgn, input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = data[{lo, 3'b000} +: 8];
        h = data[{lo[1], 4'b0000} +: 16];
        case (size)
            2'b00:   res = {{24{sgn & b[7]}}, b};
            2'b01:   res = {{16{sgn & h[15]}}, h};
            default: res = data;
        endcase
        return res;
    endfunction

    assign w_illegal    = f_illegal(req_size, req_addr[1:0]);
    assign w_store_data = f_store_lanes(req_size, req_wdata);
    assign w_load_data  = f_load_lane(r_size, r_addr_lo, r_signed, mmio_read_data);
    assign req_ready    = (r_state == IDLE);

`ifdef MMIO_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [CNT_W-1:0] r_cnt;
    // The counter holds the number of completed BUSY cycles, so reaching the limit ends this cycle.
    assign w_timeout = (r_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Access sequencer: IDLE accepts, BUSY holds the strobe until done/no-claim/timeout, RESP pulses.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_addr_lo       <= 2'b00;
            r_size          <= 2'b00;
            r_signed        <= 1'b0;
            r_first         <= 1'b0;
            mmio_read       <= 1'b0;
            mmio_write      <= 1'b0;
            mmio_addr       <= 32'h0000_0000;
            mmio_write_data <= 32'h0000_0000;
            resp_valid      <= 1'b0;
            resp_err        <= 1'b0;
            resp_rdata      <= 32'h0000_0000;
`ifdef MMIO_MASTER_TIMEOUT_EN
            r_cnt           <= {CNT_W{1'b0}};
`endif
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (w_illegal) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            r_state         <= BUSY;
                            mmio_read       <= ~req_write;
                            mmio_write      <= req_write;
                            mmio_addr       <= {req_addr[31:2], 2'b00};
                            mmio_write_data <= w_store_data;
                            r_addr_lo       <= req_addr[1:0];
                            r_size          <= req_size;
                            r_signed        <= req_signed;
                            r_first         <= 1'b1;
`ifdef MMIO_MASTER_TIMEOUT_EN
                            r_cnt           <= {CNT_W{1'b0}};
`endif
                        end
                    end
                end
                BUSY: begin
                    r_first <= 1'b0;
                    if (mmio_done) begin
                        r_state    <= RESP;
                        mmio_read  <= 1'b0;
                        mmio_write <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= mmio_write ? 32'h0000_0000 : w_load_data;
                    end else if ((r_first && !mmio_work) || w_timeout) begin
                        r_state    <= RESP;
                        mmio_read  <= 1'b0;
                        mmio_write <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
`ifdef MMIO_MASTER_TIMEOUT_EN
                        r_cnt <= r_cnt + CNT_W'(1);
`endif
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    mmio_read  <= 1'b0;
                    mmio_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_master.sv
// Bench for mmio_master: vector table plus reset, held-request and timeout sequences.
module tb_mmio_master;

    localparam int unsigned TO = 4;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mmio_read, mmio_write, mmio_work, mmio_done;
    logic [31:0] mmio_addr, mmio_write_data, mmio_read_data;

    always #5 sys_clk = ~sys_clk;

    mmio_master #(.TIMEOUT_CYCLES(TO)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mmio_read(mmio_read), .mmio_write(mmio_write),
        .mmio_addr(mmio_addr), .mmio_write_data(mmio_write_data),
        .mmio_work(mmio_work), .mmio_done(mmio_done), .mmio_read_data(mmio_read_data)
    );

    int n_checks = 0;
    int n_err    = 0;
    logic [32:0] sb_q[$];
    logic [32:0] sb_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 = completes on the bus, 1 = rejected as illegal, 2 = nobody claims it
    typedef struct {
        int          kind;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sgn;
        int          dly;
        logic [31:0] bus;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwdata;
    } vec_t;

    vec_t vecs[16];

    // Scoreboard: every response pulse must match the oldest outstanding expectation.
    always @(negedge sys_clk) begin
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", {31'd0, resp_valid}, 32'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("resp_err", {31'd0, resp_err}, {31'd0, sb_exp[32]});
                chk("resp_rdata", resp_rdata, sb_exp[31:0]);
            end
        end else begin
            chk("quiet_err", {31'd0, resp_err}, 32'd0);
            chk("quiet_rdata", resp_rdata, 32'd0);
        end
    end

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic sgn);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        req_signed = sgn;
    endtask

    task automatic chk_bus(input vec_t v, input string tag);
        chk({tag, "_rd"}, {31'd0, mmio_read}, {31'd0, ~v.wr});
        chk({tag, "_wr"}, {31'd0, mmio_write}, {31'd0, v.wr});
        chk({tag, "_addr"}, mmio_addr, v.exp_maddr);
        if (v.kind == 0) chk({tag, "_wdata"}, mmio_write_data, v.exp_mwdata);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge sys_clk);
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        drive_req(v.wr, v.addr, v.wdata, v.size, v.sgn);
        mmio_work = (v.kind != 2);
        sb_q.push_back({v.exp_err, v.exp_rdata});
        @(negedge sys_clk);
        req_valid = 1'b0;
        if (v.kind == 1) begin
            chk("illegal_no_strobe", {30'd0, mmio_read, mmio_write}, 32'd0);
            chk("illegal_resp_t1", {31'd0, resp_valid}, 32'd1);
        end else begin
            chk_bus(v, "strobe_t1");
            if (v.kind == 0) begin
                for (int i = 0; i < v.dly; i++) begin
                    @(negedge sys_clk);
                    chk_bus(v, "hold");
                end
                @(negedge sys_clk);
                chk_bus(v, "hold_done");
                mmio_done      = 1'b1;
                mmio_read_data = v.bus;
            end
            @(negedge sys_clk);
            mmio_done      = 1'b0;
            mmio_read_data = 32'h0000_0000;
            chk("resp_pulse", {31'd0, resp_valid}, 32'd1);
            chk("strobe_low_resp", {30'd0, mmio_read, mmio_write}, 32'd0);
        end
        @(negedge sys_clk);
        chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
        chk("strobe_low_idle", {30'd0, mmio_read, mmio_write}, 32'd0);
        mmio_work = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{0, 1'b0, 32'hFFFF0120, 32'h0, 2'b10, 1'b0, 0, 32'h00000001, 1'b0, 32'h00000001, 32'hFFFF0120, 32'h0};
        vecs[1]  = '{0, 1'b0, 32'hFFFF0127, 32'h0, 2'b00, 1'b1, 0, 32'h80000000, 1'b0, 32'hFFFFFF80, 32'hFFFF0124, 32'h0};
        vecs[2]  = '{0, 1'b0, 32'hFFFF0127, 32'h0, 2'b00, 1'b0, 1, 32'h80000000, 1'b0, 32'h00000080, 32'hFFFF0124, 32'h0};
        vecs[3]  = '{0, 1'b1, 32'hFFFF0134, 32'hFFFFFF41, 2'b00, 1'b0, 3, 32'h12345678, 1'b0, 32'h0, 32'hFFFF0134, 32'h41414141};
        vecs[4]  = '{1, 1'b0, 32'h00000003, 32'h0, 2'b01, 1'b0, 0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0};
        vecs[5]  = '{2, 1'b0, 32'h00000040, 32'h0, 2'b10, 1'b0, 0, 32'h0, 1'b1, 32'h0, 32'h00000040, 32'h0};
        vecs[6]  = '{1, 1'b0, 32'h00000000, 32'h0, 2'b11, 1'b0, 0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0};
        vecs[7]  = '{1, 1'b0, 32'h00000002, 32'h0, 2'b10, 1'b0, 0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0};
        vecs[8]  = '{1, 1'b1, 32'h00000005, 32'h0, 2'b01, 1'b0, 0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0};
        vecs[9]  = '{0, 1'b0, 32'h00000102, 32'h0, 2'b01, 1'b1, 0, 32'h80011234, 1'b0, 32'hFFFF8001, 32'h00000100, 32'h0};
        vecs[10] = '{0, 1'b0, 32'h00000100, 32'h0, 2'b01, 1'b0, 1, 32'h0000F00D, 1'b0, 32'h0000F00D, 32'h00000100, 32'h0};
        vecs[11] = '{0, 1'b1, 32'h00000012, 32'h1234ABCD, 2'b01, 1'b0, 0, 32'h0, 1'b0, 32'h0, 32'h00000010, 32'hABCDABCD};
        vecs[12] = '{0, 1'b1, 32'h00000020, 32'hDEADBEEF, 2'b10, 1'b0, 2, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h00000020, 32'hDEADBEEF};
        vecs[13] = '{2, 1'b1, 32'h00000030, 32'h00000077, 2'b00, 1'b0, 0, 32'h0, 1'b1, 32'h0, 32'h00000030, 32'h0};
        vecs[14] = '{0, 1'b0, 32'h00000002, 32'h0, 2'b00, 1'b1, 0, 32'h00FF0000, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h0};
        vecs[15] = '{0, 1'b0, 32'h00000003, 32'h0, 2'b00, 1'b1, 0, 32'h7F000000, 1'b0, 32'h0000007F, 32'h00000000, 32'h0};

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'b00; req_signed = 1'b0;
        mmio_work = 1'b1; mmio_done = 1'b0; mmio_read_data = 32'h0;
        repeat (3) @(negedge sys_clk);
        chk("rst_strobes", {30'd0, mmio_read, mmio_write}, 32'd0);
        chk("rst_addr", mmio_addr, 32'd0);
        chk("rst_wdata", mmio_write_data, 32'd0);
        chk("rst_resp", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge sys_clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Request held high through BUSY and RESP must not disturb the access in flight.
        @(negedge sys_clk);
        drive_req(1'b0, 32'hFFFF0200, 32'h0, 2'b10, 1'b0);
        sb_q.push_back({1'b0, 32'hCAFEF00D});
        @(negedge sys_clk);
        req_addr = 32'h00000300;
        chk("held_ready_busy", {31'd0, req_ready}, 32'd0);
        chk("held_addr_t1", mmio_addr, 32'hFFFF0200);
        @(negedge sys_clk);
        chk("held_addr_t2", mmio_addr, 32'hFFFF0200);
        mmio_done = 1'b1; mmio_read_data = 32'hCAFEF00D;
        @(negedge sys_clk);
        mmio_done = 1'b0; mmio_read_data = 32'h0;
        chk("held_resp", {31'd0, resp_valid}, 32'd1);
        @(negedge sys_clk);
        req_valid = 1'b0;
        @(negedge sys_clk);
        chk("held_not_requeued", {31'd0, mmio_read}, 32'd0);
        chk("held_ready", {31'd0, req_ready}, 32'd1);

        // Reset in the middle of BUSY: outputs clear at once and no response follows.
        @(negedge sys_clk);
        drive_req(1'b1, 32'h00000044, 32'h55AA55AA, 2'b10, 1'b0);
        @(negedge sys_clk);
        req_valid = 1'b0;
        chk("pre_rst_strobe", {31'd0, mmio_write}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_strobes", {30'd0, mmio_read, mmio_write}, 32'd0);
        chk("midrst_addr", mmio_addr, 32'd0);
        chk("midrst_wdata", mmio_write_data, 32'd0);
        chk("midrst_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        chk("ready_after_midrst", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge sys_clk);

        // Slave claims but never finishes.
        @(negedge sys_clk);
        drive_req(1'b0, 32'h00000080, 32'h0, 2'b10, 1'b0);
`ifdef MMIO_MASTER_TIMEOUT_EN
        sb_q.push_back({1'b1, 32'h0});
        @(negedge sys_clk);
        req_valid = 1'b0;
        for (int i = 0; i < int'(TO) - 1; i++) begin
            chk("to_busy_strobe", {31'd0, mmio_read}, 32'd1);
            chk("to_busy_noresp", {31'd0, resp_valid}, 32'd0);
            @(negedge sys_clk);
        end
        chk("to_last_busy", {31'd0, mmio_read}, 32'd1);
        @(negedge sys_clk);
        chk("to_resp", {31'd0, resp_valid}, 32'd1);
        chk("to_strobe_dropped", {31'd0, mmio_read}, 32'd0);
`else
        sb_q.push_back({1'b0, 32'h13579BDF});
        @(negedge sys_clk);
        req_valid = 1'b0;
        repeat (1000) @(negedge sys_clk);
        chk("wait_still_busy", {31'd0, mmio_read}, 32'd1);
        chk("wait_not_ready", {31'd0, req_ready}, 32'd0);
        mmio_done = 1'b1; mmio_read_data = 32'h13579BDF;
        @(negedge sys_clk);
        mmio_done = 1'b0; mmio_read_data = 32'h0;
        chk("wait_resp", {31'd0, resp_valid}, 32'd1);
`endif
        @(negedge sys_clk);
        chk("final_ready", {31'd0, req_ready}, 32'd1);
        @(negedge sys_clk);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
